// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Recovers operand factors downstream of the DSP pipeline (e.g. P / A).
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_start        request, sampled on rising edge while idle or done
//   i_dividend     DW-bit unsigned dividend, captured when start is accepted
//   i_divisor      VW-bit unsigned divisor, captured when start is accepted
//   o_busy         high while a division is iterating
//   o_done         one-cycle pulse when results are valid
//   o_div_by_zero  valid with done; high if the captured divisor was 0
//   o_quotient     DW-bit quotient (all ones on divide by zero)
//   o_remainder    VW-bit remainder (0 on divide by zero)
module seq_divider #(
  parameter int DW = 48,
  parameter int VW = 18
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_dividend,
  input  logic [VW-1:0] i_divisor,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_div_by_zero,
  output logic [DW-1:0] o_quotient,
  output logic [VW-1:0] o_remainder
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [DW-1:0] r_dvd;    // dividend shift register; quotient bits shift in at the LSB
  logic [VW-1:0] r_dvs;
  logic [VW-1:0] r_rem;    // partial remainder, always < divisor between iterations
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_dbz;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_remo;

  logic [VW:0]   w_shift_rem;
  logic [VW+1:0] w_trial;
  logic          w_ge;
  logic [VW-1:0] w_rem_next;
  logic [DW-1:0] w_q_next;
  logic          w_dvs_zero;
  logic          w_in_zero;

  // Shifted partial remainder needs VW+1 bits; one more bit carries the borrow.
  assign w_shift_rem = {r_rem, r_dvd[DW-1]};
  assign w_trial     = {1'b0, w_shift_rem} - {2'b00, r_dvs};
  // A non-negative trial is always < divisor, so its top two bits are both zero;
  // a negative trial has the borrow bit set.
  assign w_ge        = (w_trial[VW+1:VW] == 2'b00);
  assign w_rem_next  = w_ge ? w_trial[VW-1:0] : w_shift_rem[VW-1:0];
  assign w_q_next    = {r_dvd[DW-2:0], w_ge};
  assign w_dvs_zero  = (r_dvs == '0);
  assign w_in_zero   = (i_divisor == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
          if (i_start) begin
            r_dvd   <= i_dividend;
            r_dvs   <= i_divisor;
            r_rem   <= '0;
            r_state <= S_RUN;
            // A zero divisor takes a single silent RUN cycle (busy stays low)
            // so its done pulse lands one edge after acceptance.
            r_cnt   <= w_in_zero ? CW'(1) : CW'(DW);
            r_busy  <= !w_in_zero;
          end
        end
        S_RUN: begin
          r_dvd <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_dbz   <= w_dvs_zero;
            r_quot  <= w_dvs_zero ? '1 : w_q_next;
            r_remo  <= w_dvs_zero ? '0 : w_rem_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_quotient    = r_quot;
  assign o_remainder   = r_remo;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider with a queue scoreboard.
module tb_seq_divider;

  localparam int DW = 48;
  localparam int VW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [DW-1:0] i_dividend = '0;
  logic [VW-1:0] i_divisor = '0;
  logic          o_busy;
  logic          o_done;
  logic          o_div_by_zero;
  logic [DW-1:0] o_quotient;
  logic [VW-1:0] o_remainder;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
  } exp_t;

  exp_t sb[$];

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(i_start),
    .i_dividend(i_dividend),
    .i_divisor(i_divisor),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_div_by_zero(o_div_by_zero),
    .o_quotient(o_quotient),
    .o_remainder(o_remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer division, all ones / 0 on a zero divisor.
  task automatic push_exp(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs);
    exp_t e;
    logic [63:0] a;
    logic [63:0] b;
    e.dvd = dvd;
    e.dvs = dvs;
    if (dvs == '0) begin
      e.q = '1;
      e.r = '0;
      e.dbz = 1'b1;
    end else begin
      a = {16'd0, dvd};
      b = {46'd0, dvs};
      e.q = DW'(a / b);
      e.r = VW'(a % b);
      e.dbz = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Present one operation for a single accepting edge; returns at #1 after it.
  task automatic start_op(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs);
    @(negedge clk);
    i_dividend = dvd;
    i_divisor  = dvs;
    i_start    = 1'b1;
    push_exp(dvd, dvs);
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  // Called at #1 after the accepting edge; waits (bounded) for done and scores it.
  task automatic wait_result(input int exp_lat, input int exp_busy, output time t_done);
    int lat = 0;
    int nb = 0;
    bit got = 1'b0;
    exp_t e;
    logic [79:0] prod;
    for (int c = 0; c < 200; c++) begin
      check("busy_done_excl", {63'd0, o_busy & o_done}, 64'd0);
      if (o_busy) nb++;
      if (o_done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    t_done = $time;
    check("done_seen", {63'd0, got}, 64'd1);
    if (got) begin
      check("latency", 64'(lat), 64'(exp_lat));
      check("busy_cycles", 64'(nb), 64'(exp_busy));
    end
    if (sb.size() == 0) begin
      check("sb_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check("quotient", {16'd0, o_quotient}, {16'd0, e.q});
      check("remainder", {46'd0, o_remainder}, {46'd0, e.r});
      check("div_by_zero", {63'd0, o_div_by_zero}, {63'd0, e.dbz});
      if (!e.dbz) begin
        prod = 80'(o_quotient) * 80'(e.dvs) + 80'(o_remainder);
        check("identity", {63'd0, prod == 80'(e.dvd)}, 64'd1);
        check("rem_lt_div", {63'd0, o_remainder < e.dvs}, 64'd1);
      end
      $display("[TB] %0d / %0d -> q=%0d r=%0d dbz=%0b lat=%0d", e.dvd, e.dvs,
               o_quotient, o_remainder, o_div_by_zero, lat);
    end
  endtask

  task automatic check_pulse_end();
    @(posedge clk);
    #1;
    check("done_one_cycle", {63'd0, o_done}, 64'd0);
  endtask

  task automatic check_no_done(input int cycles);
    int nd = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (o_done) nd++;
    end
    check("no_done", 64'(nd), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
    check({tag, "_done"}, {63'd0, o_done}, 64'd0);
    check({tag, "_dbz"}, {63'd0, o_div_by_zero}, 64'd0);
    check({tag, "_quot"}, {16'd0, o_quotient}, 64'd0);
    check({tag, "_rem"}, {46'd0, o_remainder}, 64'd0);
  endtask

  initial begin
    time t;
    time t_prev;
    logic [DW-1:0] rd;
    logic [VW-1:0] rv;

    // Reset with all inputs at zero.
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic operations.
    start_op(48'd1000, 18'd7);
    wait_result(48, 48, t);
    check_pulse_end();
    start_op(48'd5, 18'd9);
    wait_result(48, 48, t);
    check_pulse_end();
    start_op(48'hFFFF_FFFF_FFFF, 18'd1);
    wait_result(48, 48, t);
    check_pulse_end();

    // Divide by zero, then a normal division clears the flag.
    start_op(48'd123, 18'd0);
    wait_result(1, 0, t);
    check_pulse_end();
    start_op(48'd100, 18'd10);
    wait_result(48, 48, t);
    check_pulse_end();

    // Start during RUN is ignored.
    start_op(48'd1000, 18'd7);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    i_dividend = 48'd99;
    i_divisor  = 18'd3;
    i_start    = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_result(37, 37, t);
    check_no_done(60);

    // Reset in the middle of RUN drops the operation.
    start_op(48'd1000, 18'd7);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrun_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_no_done(60);
    start_op(48'd200, 18'd9);
    wait_result(48, 48, t);
    check_pulse_end();

    // Back-to-back random operations with start held high.
    @(negedge clk);
    rd = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    rv = 18'($urandom_range(1, 262143));
    i_dividend = rd;
    i_divisor  = rv;
    i_start    = 1'b1;
    push_exp(rd, rv);
    @(posedge clk);
    #1;
    t_prev = 0;
    for (int i = 0; i < 300; i++) begin
      if (i < 299) begin
        rd = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
        rv = ($urandom_range(0, 3) == 0) ? 18'($urandom_range(1, 15))
                                          : 18'($urandom_range(1, 262143));
        i_dividend = rd;
        i_divisor  = rv;
        push_exp(rd, rv);
      end else begin
        i_start = 1'b0;
      end
      wait_result(48, 48, t);
      if (i > 0) check("done_spacing", 64'(t - t_prev), 64'd490);
      t_prev = t;
      if (i < 299) begin
        @(posedge clk);
        #1;
      end
    end
    check_pulse_end();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
